// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM,
//            MEM/WB) using a valid/ready handshake and a 2-entry skid buffer.
//            in_ready is a flop, so downstream stalls never form a
//            combinational ready path back up the pipeline. One transfer per
//            cycle is sustained while the consumer keeps out_ready high.
//            flush inserts a bubble and overrides every other event.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH    payload width in bits (stage bundle packed by the instantiator)
//   CLR_VAL  value loaded into main and skid registers on reset and on flush
// Ports:
//   CLK        in   1      clock, rising edge
//   nRST       in   1      asynchronous active-low reset
//   flush      in   1      synchronous clear, highest priority
//   in_valid   in   1      upstream presents a payload
//   in_ready   out  1      stage can accept a payload (registered)
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      downstream payload valid (registered)
//   out_ready  in   1      downstream accepts the payload
//   out_data   out  WIDTH  downstream payload, straight from the main register
// Optional (macro PIPE_SKID_STAGE_PERF_EN):
//   stall_cnt  out  32     cycles with out_valid & !out_ready (saturating)
//   flush_cnt  out  16     flushes that killed at least one entry (saturating)
//   full_cnt   out  32     cycles spent with both entries occupied (saturating)
// ============================================================================
module pipe_skid_stage #(
  parameter int               WIDTH   = 64,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STAGE_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [15:0]      flush_cnt,
  output logic [31:0]      full_cnt
`endif
);

  // --------------------------------------------------------------------------
  // Occupancy encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_EMPTY = 2'd0;  // main invalid
  localparam logic [1:0] c_ONE   = 2'd1;  // main valid, skid empty
  localparam logic [1:0] c_FULL  = 2'd2;  // main and skid valid

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_in_fire;
  logic             w_out_fire;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;

  // Both fire terms use registered handshake outputs only, so neither
  // depends combinationally on the other side of the stage.
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // --------------------------------------------------------------------------
  // Next-state and payload steering
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;

    if (flush) begin
      // Bubble insertion: drop held entries and any same-cycle acceptance.
      w_state_nxt = c_EMPTY;
      w_main_nxt  = CLR_VAL;
      w_skid_nxt  = CLR_VAL;
    end else begin
      case (r_state)
        c_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = c_ONE;
            w_main_nxt  = in_data;
          end
        end

        c_ONE: begin
          case ({w_in_fire, w_out_fire})
            2'b11: begin
              // Pass-through: new payload replaces the one being consumed.
              w_main_nxt = in_data;
            end
            2'b10: begin
              // Consumer stalled; park the new payload behind main.
              w_state_nxt = c_FULL;
              w_skid_nxt  = in_data;
            end
            2'b01: begin
              // main keeps its stale payload; out_valid marks it invalid.
              w_state_nxt = c_EMPTY;
            end
            default: begin
              w_state_nxt = c_ONE;
            end
          endcase
        end

        c_FULL: begin
          // in_ready is low here, so only the output side can move.
          if (w_out_fire) begin
            w_state_nxt = c_ONE;
            w_main_nxt  = r_skid;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean bubble.
          w_state_nxt = c_EMPTY;
          w_main_nxt  = CLR_VAL;
          w_skid_nxt  = CLR_VAL;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and payload registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= c_EMPTY;
      r_main      <= CLR_VAL;
      r_skid      <= CLR_VAL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      // Handshake outputs are decoded from the next state so they are
      // plain flop outputs, with no logic between register and port.
      r_in_ready  <= (w_state_nxt != c_FULL);
      r_out_valid <= (w_state_nxt != c_EMPTY);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;

`ifdef PIPE_SKID_STAGE_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters: saturate at all-ones, cleared by nRST only.
  // --------------------------------------------------------------------------
  logic [31:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic [31:0] r_full_cnt;

  logic        w_stall_evt;
  logic        w_kill_evt;
  logic        w_full_evt;

  assign w_stall_evt = r_out_valid & ~out_ready;
  assign w_kill_evt  = flush & (r_state != c_EMPTY);
  assign w_full_evt  = (r_state == c_FULL);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_full_cnt  <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_kill_evt && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
      if (w_full_evt && (r_full_cnt != '1)) begin
        r_full_cnt <= r_full_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign full_cnt  = r_full_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage
// Purpose  : Self-checking bench for pipe_skid_stage. A directed vector table
//            covers streaming, skid backpressure, flush and simultaneous
//            fires; hand sequences cover asynchronous reset (and the perf
//            counters when PIPE_SKID_STAGE_PERF_EN is defined); a randomized
//            phase is checked against a queue-based occupancy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

  localparam int          WIDTH = 64;
  localparam logic [63:0] CLR   = 64'hC1EA_0000_DEAD_0001;

  logic             CLK;
  logic             nRST;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_SKID_STAGE_PERF_EN
  logic [31:0]      stall_cnt;
  logic [15:0]      flush_cnt;
  logic [31:0]      full_cnt;
`endif

  pipe_skid_stage #(
    .WIDTH   (WIDTH),
    .CLR_VAL (CLR)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_SKID_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .full_cnt  (full_cnt)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // One directed cycle: inputs applied before the edge, expectations after.
  typedef struct packed {
    logic        fl;
    logic        iv;
    logic [63:0] d;
    logic        ordy;
    logic        ev;
    logic [63:0] ed;
    logic        er;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [0:NV-1];

  // Behavioural model: the stage is a FIFO of capacity two.
  logic [63:0] mq[$];
  logic [63:0] m_last;
  logic        m_ready;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //            fl   iv   data   ordy  ev   exp data er
    // streaming 1,2,3 then drain
    tbl[0]  = '{1'b0, 1'b1, 64'h1, 1'b1, 1'b1, 64'h1, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 64'h2, 1'b1, 1'b1, 64'h2, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 64'h3, 1'b1, 1'b1, 64'h3, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h3, 1'b1};
    // backpressure into skid: A held, B parked, C held off, drain A,B,C
    tbl[4]  = '{1'b0, 1'b1, 64'hA, 1'b1, 1'b1, 64'hA, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 64'hB, 1'b0, 1'b1, 64'hA, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 64'hC, 1'b0, 1'b1, 64'hA, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 64'hC, 1'b1, 1'b1, 64'hB, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 64'hC, 1'b1, 1'b1, 64'hC, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'hC, 1'b1};
    // flush in FULL with a competing input D
    tbl[10] = '{1'b0, 1'b1, 64'hA, 1'b0, 1'b1, 64'hA, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 64'hB, 1'b0, 1'b1, 64'hA, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 64'hD, 1'b0, 1'b0, CLR,   1'b1};
    tbl[13] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, CLR,   1'b1};
    // simultaneous fires in ONE
    tbl[14] = '{1'b0, 1'b1, 64'h5, 1'b0, 1'b1, 64'h5, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 64'h6, 1'b1, 1'b1, 64'h6, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h6, 1'b1};
    // flush in ONE, then flush in EMPTY with an offered payload
    tbl[17] = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b0, CLR,   1'b1};
    tbl[18] = '{1'b1, 1'b1, 64'h7, 1'b0, 1'b0, CLR,   1'b1};

    // ---------------- reset state (asynchronous assertion) ----------------
    #2 nRST = 1'b0;
    #1;
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset out_data",  out_data,           CLR);
    chk("reset in_ready",  {63'd0, in_ready},  64'd1);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // ---------------- directed table ----------------
    for (int i = 0; i < NV; i++) begin
      flush     = tbl[i].fl;
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].ordy;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].ev});
      chk($sformatf("vec%0d out_data", i),  out_data,           tbl[i].ed);
      chk($sformatf("vec%0d in_ready", i),  {63'd0, in_ready},  {63'd0, tbl[i].er});
    end
    flush = 1'b0;

    // ---------------- async reset while FULL ----------------
    in_valid = 1'b1; in_data = 64'hA1; out_ready = 1'b0;
    @(posedge CLK); #1;
    in_data = 64'hA2;
    @(posedge CLK); #1;
    chk("full before reset in_ready",  {63'd0, in_ready},  64'd0);
    chk("full before reset out_valid", {63'd0, out_valid}, 64'd1);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("async reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("async reset in_ready",  {63'd0, in_ready},  64'd1);
    chk("async reset out_data",  out_data,           CLR);
    @(negedge CLK);
    nRST = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge CLK); #1;
    chk("post reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("post reset out_data",  out_data,           CLR);

`ifdef PIPE_SKID_STAGE_PERF_EN
    // ---------------- perf counters ----------------
    do_reset();
    in_valid = 1'b1; in_data = 64'h11; out_ready = 1'b0;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("perf stall_cnt", {32'd0, stall_cnt}, 64'd5);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1;
    chk("perf flush_cnt one", {48'd0, flush_cnt}, 64'd1);
    @(posedge CLK); #1;
    flush = 1'b0;
    chk("perf flush_cnt empty", {48'd0, flush_cnt}, 64'd1);
    chk("perf stall_cnt kept",  {32'd0, stall_cnt}, 64'd5);
    chk("perf full_cnt",        {32'd0, full_cnt},  64'd0);
`endif

    // ---------------- randomized vs. FIFO model ----------------
    do_reset();
    mq.delete();
    m_last  = CLR;
    m_ready = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic ifire;
      logic ofire;
      flush     = ($urandom_range(0, 31) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      out_ready = (c % 400 < 200) ? ($urandom_range(0, 3) != 0)
                                  : ($urandom_range(0, 3) == 0);
      ifire = in_valid && m_ready;
      ofire = (mq.size() != 0) && out_ready;
      if (flush) begin
        mq.delete();
        m_last = CLR;
      end else begin
        if (ofire) void'(mq.pop_front());
        if (ifire) mq.push_back(in_data);
        if (mq.size() != 0) m_last = mq[0];
      end
      m_ready = (mq.size() < 2);
      @(posedge CLK);
      #1;
      if ((out_valid !== (mq.size() != 0)) || (out_data !== m_last) ||
          (in_ready !== m_ready)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rand%0d: got v=%b d=%h r=%b expected v=%b d=%h r=%b",
                 c, out_valid, out_data, in_ready, (mq.size() != 0), m_last, m_ready);
      end else begin
        n_cmp++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Generic, parametrised inter-stage pipeline register for the processor datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the hand-coded per-stage latches that use a write-enable and a clear.
- Uses a valid/ready handshake with a 2-entry skid buffer. Stalls never create a combinational ready path back through the pipeline, and one transfer per cycle is sustained.
- Flush (bubble insertion) is synchronous and has priority over every other event.

Parameters:
- WIDTH, 64, payload width in bits (the stage bundle, packed by the instantiating module).
- CLR_VAL, '0 (WIDTH bits), value loaded into both payload registers on reset and on flush.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear; discards all held entries and any transfer in the same cycle.
- in_valid  in  1  upstream stage presents a payload.
- in_ready  out  1  stage can accept a payload; registered.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts the payload.
- out_data  out  WIDTH  downstream payload; driven directly from the main register.

Behaviour:
- Reset: nRST low, reset is asynchronous and clock-independent.
  - State goes to EMPTY; main and skid registers load CLK_VAL... correction: they load CLR_VAL.
  - Outputs: out_valid=0, out_data=CLR_VAL, in_ready=1.
- Fire definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- States, each held with its payload registers:
  - EMPTY: main invalid. out_valid=0, in_ready=1.
  - ONE: main valid, skid empty. out_valid=1, in_ready=1.
  - FULL: main and skid both valid. out_valid=1, in_ready=0.
- Transitions when flush=0:
  - EMPTY: in_fire -> ONE, main<=in_data. Otherwise stay.
  - ONE: in_fire & out_fire -> ONE, main<=in_data.
  - ONE: in_fire & !out_fire -> FULL, skid<=in_data.
  - ONE: !in_fire & out_fire -> EMPTY.
  - ONE: neither fire -> hold.
  - FULL: out_fire -> ONE, main<=skid. No input is accepted because in_ready=0. Otherwise hold.
- Registered ready: in_ready is a flop. Its next value is 1 unless the next state is FULL.
- Flush: flush=1 at a clock edge takes priority over every transition above.
  - Next state is EMPTY; main and skid load CLR_VAL.
  - Any in_fire that cycle is discarded.
  - out_fire that cycle still counts for the downstream consumer; the consumer decides whether to honour it.
  - in_ready is 1 on the following cycle.
- Latency and throughput:
  - A payload accepted at edge N is on out_data with out_valid=1 after edge N (1-cycle latency).
  - Sustains 1 transfer/cycle while out_ready=1.
- Data stability: while out_valid=1 & out_ready=0, out_data and out_valid hold unchanged.
- Ordering: strict FIFO order; the skid entry is always older than any later input.
- Undefined inputs: in_data is ignored when in_valid=0; no X propagation into the held registers.

Optional Feature:
- Macro: PIPE_SKID_STAGE_PERF_EN.
- When defined, three additional outputs are added, each saturating at all-ones:
  - stall_cnt [31:0]: counts cycles with out_valid & !out_ready.
  - flush_cnt [15:0]: counts cycles with flush=1 while state!=EMPTY (entries actually killed).
  - full_cnt [31:0]: counts cycles spent in FULL.
- Counter clearing: counters clear on nRST only; flush does not clear them.
- When the macro is undefined: the ports and logic are absent and the core behaviour is identical.

Test Plan:
- Reset and streaming: WIDTH=64, reset, then in_valid=1 with data 0x1,0x2,0x3 on consecutive cycles and out_ready=1 -> in_ready=1 throughout; out_data 0x1,0x2,0x3 each 1 cycle after acceptance; no gaps.
- Backpressure into skid: with 0xA held in ONE, set out_ready=0 and offer 0xB -> FULL; in_ready=0 next cycle; 0xC is held off. Raise out_ready -> output order 0xA, 0xB, 0xC; no loss, no duplication.
- Flush in FULL: holding 0xA/0xB, assert flush for 1 cycle with in_valid=1 data 0xD -> next cycle out_valid=0, out_data=CLR_VAL, in_ready=1; 0xD never appears at the output.
- Simultaneous fires in ONE: hold 0x5, then in_fire of 0x6 and out_fire in the same cycle -> stays ONE; out_data=0x6 next cycle; skid unused; in_ready stays 1.
- Async reset mid-operation: in FULL, pulse nRST low between clock edges -> out_valid=0 and in_ready=1 immediately, without a clock edge; no stale data after release.
- Perf counters (PIPE_SKID_STAGE_PERF_EN): 5 stall cycles then 1 flush while ONE -> stall_cnt=5, flush_cnt=1; a later flush while EMPTY leaves flush_cnt=1.
